// File: rtl/vec_seq_pkg.sv
// Shared types and op encodings for the interrupt/reset vector sequencer.
// The ABH/ABL units decode the same op constants.
`timescale 1ns/1ps
package vec_seq_pkg;

   typedef enum logic [2:0] {
      ST_RH   = 3'd0,
      ST_IDLE = 3'd1,
      ST_PH   = 3'd2,
      ST_PL   = 3'd3,
      ST_PP   = 3'd4,
      ST_VL   = 3'd5,
      ST_VH   = 3'd6,
      ST_LD   = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_NMI  = 3'd1,
      SRC_RST  = 3'd2,
      SRC_IRQ  = 3'd3,
      SRC_BRK  = 3'd4
   } src_e;

   // abh_op[3:2] selects the page source, abh_op[1:0] the byte source
   localparam logic [1:0] ABH_OP_PAGE0  = 2'b00;
   localparam logic [1:0] ABH_OP_PAGE1  = 2'b01;
   localparam logic [1:0] ABH_OP_ARITH  = 2'b10;
   localparam logic [1:0] ABH_OP_PAGEFF = 2'b11;
   localparam logic [1:0] ABH_OP_ABH    = 2'b00;
   localparam logic [1:0] ABH_OP_DEC    = 2'b01;
   localparam logic [1:0] ABH_OP_PCH    = 2'b10;
   localparam logic [1:0] ABH_OP_DB     = 2'b11;

   localparam logic [2:0] ABL_OP_PC     = 3'd0;
   localparam logic [2:0] ABL_OP_SP     = 3'd1;
   localparam logic [2:0] ABL_OP_VEC_LO = 3'd2;
   localparam logic [2:0] ABL_OP_VEC_HI = 3'd3;
   localparam logic [2:0] ABL_OP_DB     = 3'd4;

   localparam logic [1:0] VEC_NONE = 2'd0;
   localparam logic [1:0] VEC_NMI  = 2'd1;
   localparam logic [1:0] VEC_RST  = 2'd2;
   localparam logic [1:0] VEC_IRQ  = 2'd3;

   localparam logic [1:0] DO_PCH = 2'd0;
   localparam logic [1:0] DO_PCL = 2'd1;
   localparam logic [1:0] DO_P   = 2'd2;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [3:0] abh_op;
      logic [2:0] abl_op;
      logic [1:0] vec_sel;
      logic       we;
      logic [1:0] do_sel;
      logic       b_bit;
      logic       sp_dec;
      logic       lat_lo;
      logic       ld_pc;
      logic       inc_pc;
      logic       set_i;
      logic       clr_d;
      logic       nmi_ack;
   } ctl_t;

   localparam ctl_t CTL_RESET = '{busy: 1'b1, done: 1'b0, abh_op: {ABH_OP_PAGE1, ABH_OP_ABH},
                                  abl_op: ABL_OP_SP, vec_sel: VEC_RST, we: 1'b0, do_sel: DO_PCH,
                                  b_bit: 1'b0, sp_dec: 1'b0, lat_lo: 1'b0, ld_pc: 1'b0,
                                  inc_pc: 1'b0, set_i: 1'b0, clr_d: 1'b0, nmi_ack: 1'b0};

   function automatic src_e src_select(input logic nmi, input logic irq,
                                       input logic i_flag, input logic brk);
      src_e s;
      if (nmi) begin
         s = SRC_NMI;
      end else if (irq && !i_flag) begin
         s = SRC_IRQ;
      end else if (brk) begin
         s = SRC_BRK;
      end else begin
         s = SRC_NONE;
      end
      return s;
   endfunction

   function automatic logic [1:0] vec_of(input src_e src);
      logic [1:0] v;
      case (src)
         SRC_NMI:          v = VEC_NMI;
         SRC_RST:          v = VEC_RST;
         SRC_IRQ, SRC_BRK: v = VEC_IRQ;
         default:          v = VEC_NONE;
      endcase
      return v;
   endfunction

   // Moore output decode; brk_seq remembers a BRK entry even after an NMI hijack
   function automatic ctl_t ctl_decode(input state_e st, input src_e src, input logic brk_seq);
      ctl_t c;
      c         = '0;
      c.busy    = 1'b1;
      c.abh_op  = {ABH_OP_PAGE1, ABH_OP_ABH};
      c.abl_op  = ABL_OP_SP;
      c.vec_sel = vec_of(src);
      case (st)
         ST_RH: begin
            c.vec_sel = VEC_RST;
         end
         ST_IDLE: begin
            c.busy    = 1'b0;
            c.abh_op  = {ABH_OP_ARITH, ABH_OP_PCH};
            c.abl_op  = ABL_OP_PC;
            c.vec_sel = VEC_NONE;
         end
         ST_PH, ST_PL, ST_PP: begin
            // reset entry performs the three pushes as dummy reads
            c.we     = (src != SRC_RST);
            c.sp_dec = 1'b1;
            c.do_sel = (st == ST_PH) ? DO_PCH : ((st == ST_PL) ? DO_PCL : DO_P);
            c.b_bit  = (st == ST_PP) && brk_seq;
         end
         ST_VL: begin
            c.abh_op  = {ABH_OP_PAGEFF, ABH_OP_ABH};
            c.abl_op  = ABL_OP_VEC_LO;
            c.set_i   = 1'b1;
            c.clr_d   = 1'b1;
            c.nmi_ack = (src == SRC_NMI);
         end
         ST_VH: begin
            c.abh_op = {ABH_OP_PAGEFF, ABH_OP_ABH};
            c.abl_op = ABL_OP_VEC_HI;
            c.lat_lo = 1'b1;
         end
         ST_LD: begin
            c.abh_op = {ABH_OP_ARITH, ABH_OP_DB};
            c.abl_op = ABL_OP_DB;
            c.ld_pc  = 1'b1;
            c.done   = 1'b1;
         end
         default: begin
            c = CTL_RESET;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vec_seq.sv
// Reset/NMI/IRQ/BRK entry sequencer: pushes PC and P, fetches the vector, loads PC.
// Outputs are registered from the next-state decode so they change only on rdy edges.
`timescale 1ns/1ps
module vec_seq
   import vec_seq_pkg::*;
#(
   parameter logic [7:0] VEC_PAGE   = 8'hFF,
   parameter int         NMI_HIJACK = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rdy,
   input  logic       start,
   input  logic       brk,
   input  logic       nmi_pend,
   input  logic       irq_pend,
   input  logic       i_flag,
   output logic       busy,
   output logic       done,
   output logic [3:0] abh_op,
   output logic [2:0] abl_op,
   output logic [1:0] vec_sel,
   output logic       we,
   output logic [1:0] do_sel,
   output logic       b_bit,
   output logic       sp_dec,
   output logic       lat_lo,
   output logic       ld_pc,
   output logic       inc_pc,
   output logic       set_i,
   output logic       clr_d,
   output logic       nmi_ack
);

   if (VEC_PAGE != 8'hFF) begin : g_vec_page_check
      $error("vec_seq: the vector page is hardwired to FF in the ABH unit");
   end

   state_e state_q, state_d;
   src_e   src_q, src_d;
   logic   brk_q, brk_d;
   ctl_t   ctl_q, ctl_d;
   src_e   entry_src;
   logic   take_nmi;

   // next-state logic; everything holds while rdy is low
   always_comb begin
      entry_src = src_select(nmi_pend, irq_pend, i_flag, brk);
      take_nmi  = (NMI_HIJACK != 32'sd0) && nmi_pend &&
                  ((src_q == SRC_IRQ) || (src_q == SRC_BRK));
      state_d   = state_q;
      src_d     = src_q;
      brk_d     = brk_q;
      if (rdy) begin
         case (state_q)
            ST_RH: begin
               state_d = ST_PH;
            end
            ST_IDLE: begin
               if (start && (entry_src != SRC_NONE)) begin
                  state_d = ST_PH;
                  src_d   = entry_src;
                  brk_d   = (entry_src == SRC_BRK);
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PH, ST_PL, ST_PP: begin
               state_d = (state_q == ST_PH) ? ST_PL : ((state_q == ST_PL) ? ST_PP : ST_VL);
               if (take_nmi) begin
                  src_d = SRC_NMI;
               end else begin
                  src_d = src_q;
               end
            end
            ST_VL: begin
               state_d = ST_VH;
            end
            ST_VH: begin
               state_d = ST_LD;
            end
            ST_LD: begin
               state_d = ST_IDLE;
               src_d   = SRC_NONE;
               brk_d   = 1'b0;
            end
            default: begin
               state_d = ST_RH;
               src_d   = SRC_RST;
               brk_d   = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      ctl_d = ctl_decode(state_d, src_d, brk_d);
   end

   // state, source and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RH;
         src_q   <= SRC_RST;
         brk_q   <= 1'b0;
         ctl_q   <= CTL_RESET;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         brk_q   <= brk_d;
         ctl_q   <= ctl_d;
      end
   end

   assign busy    = ctl_q.busy;
   assign done    = ctl_q.done;
   assign abh_op  = ctl_q.abh_op;
   assign abl_op  = ctl_q.abl_op;
   assign vec_sel = ctl_q.vec_sel;
   assign we      = ctl_q.we;
   assign do_sel  = ctl_q.do_sel;
   assign b_bit   = ctl_q.b_bit;
   assign sp_dec  = ctl_q.sp_dec;
   assign lat_lo  = ctl_q.lat_lo;
   assign ld_pc   = ctl_q.ld_pc;
   assign inc_pc  = ctl_q.inc_pc;
   assign set_i   = ctl_q.set_i;
   assign clr_d   = ctl_q.clr_d;
   assign nmi_ack = ctl_q.nmi_ack;

endmodule
